serial_add_engine: RTL
======================

Name: serial_add_engine

Overview:
- Bit-serial N-bit adder built around a one-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)) plus a carry flip-flop.
- Loads two operands through a valid/ready input port and shifts them LSB-first through the cell, one bit per clock.
- Collects the serial sum into a shift register and presents the result on a valid/ready output port.
- Serves as the sequencing stage that feeds the combinational bit cell and consumes its sum/carry, trading area for latency in wide datapaths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin are valid this cycle
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A, unsigned or two's complement
b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  result held and valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of MSB
ovf  output  1  signed overflow (carry into MSB xor carry out of MSB)

Behaviour:
Reset:
- rst_n low, asynchronous: state=IDLE; operand shift regs, sum shift reg, carry FF, bit counter, sum, cout, ovf all 0; out_valid=0.
- in_ready is combinational from state, so it reads 1 during reset.
- Reset asserted mid-operation aborts the operation with no output pulse. After release the block is in IDLE with in_ready=1.

States:
- IDLE: in_ready=1, out_valid=0.
  - On edge with in_valid=1: load A_sr=a, B_sr=b, carry=cin, cnt=0; go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT: in_ready=0. Each edge:
  - sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}, where the cell inputs are A_sr[0], B_sr[0], carry.
  - A_sr, B_sr shift right by 1; carry <= fa_carry; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1:
    - Register sum = final shifted sum_sr, cout = fa_carry, ovf = carry ^ fa_carry. Here carry is the carry into the MSB.
    - Go to DONE.
  - in_valid is ignored while in SHIFT.
- DONE: out_valid=1; sum, cout, ovf are stable.
  - On edge with out_ready=1: go to IDLE. Outputs keep their last values.
  - out_ready=0: hold indefinitely (backpressure).
  - No input accept in DONE; in_ready=0.

Latency and throughput:
- Accept edge T0, shift edges T1..TWIDTH. out_valid is high in the cycle after TWIDTH, i.e. WIDTH edges after accept.
- Best-case throughput: one operation per WIDTH+2 cycles (accept, WIDTH shifts, handshake, return to IDLE).

Width and arithmetic:
- cnt width = max(1, clog2(WIDTH)).
- Result is exact modulo 2^WIDTH; cout and ovf are always computed, whatever the signedness.
- WIDTH=1: a single shift cycle; ovf = cin ^ cout.

Boundaries:
- in_valid held high across an operation starts a new one only on the first IDLE cycle after DONE handshakes.
- out_ready high on arrival in DONE: out_valid is high for exactly one cycle.
- sum, cout, ovf change only on the final SHIFT edge or on reset.

Test Plan:
1. WIDTH=8, a=8'h00, b=8'h00, cin=0, out_ready=1 -> out_valid rises exactly 8 edges after the accept edge; sum=8'h00, cout=0, ovf=0; out_valid high 1 cycle; in_ready high the next cycle.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
3. a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1, ovf=0. a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, ovf=1.
4. Backpressure: result 8'h3C, hold out_ready=0 for 5 cycles -> out_valid stays 1, sum stays 8'h3C, in_ready stays 0. The in_valid pulse applied meanwhile is ignored. Raise out_ready -> IDLE next cycle.
5. Reset mid-operation: accept a=8'h12, b=8'h34, pull rst_n low after 3 shift edges -> immediately out_valid=0, sum=0, cout=0, ovf=0. After release, in_ready=1 and the next op a=8'h01, b=8'h02 gives sum=8'h03.
6. WIDTH=1 build, all 8 combinations of a, b, cin -> sum/cout match the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1), with out_valid 1 edge after accept.

Source files
------------

// File: rtl/serial_add_engine.sv
// Bit-serial adder: operands shift LSB-first through a one-bit
// full-adder cell and a carry flop, collecting the sum serially.

// One-bit full-adder cell driven by the sequencing stage below
module serial_add_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    // Sum is odd parity, carry is the majority of the three inputs
    always_comb begin
        o_sum   = i_a ^ i_b ^ i_c;
        o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    end

endmodule

module serial_add_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int CW = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic [WIDTH-1:0] w_sum_sr_nxt;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_accept;
    logic             w_last;

    serial_add_fa_cell u_cell (
        .i_a     (r_a_sr[0]),
        .i_b     (r_b_sr[0]),
        .i_c     (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts
    // bit 0 of the result sits at bit 0 of the register
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_sr_nxt = w_fa_sum;
        end else begin : g_wn
            assign w_sum_sr_nxt = {w_fa_sum, r_sum_sr[WIDTH-1:1]};
        end
    endgenerate

    assign w_accept    = (r_state == S_IDLE) && i_in_valid;
    assign w_last      = (r_state == S_SHIFT) && (r_cnt == LAST);
    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

    // Next-state: accept, shift WIDTH bits, hold until handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand load and LSB-first shift through the cell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sr  <= i_a;
            r_b_sr  <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_sum_sr <= w_sum_sr_nxt;
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_carry  <= w_fa_carry;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Result capture on the final shift; carry here is the MSB carry-in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_sum_sr_nxt;
            r_cout <= w_fa_carry;
            r_ovf  <= r_carry ^ w_fa_carry;
        end
    end

endmodule
